// File: rtl/matrix_result_streamer_if.sv
// Result beat stream leaving matrix_result_streamer: one element per valid/ready
// transfer, tagged with its row/col position and an end-of-frame flag.
interface matrix_result_streamer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ROW_W      = 3,
    parameter int COL_W      = 3
);
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [ROW_W-1:0]      out_row;
    logic [COL_W-1:0]      out_col;
    logic                  out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_row,
        output out_col,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_row,
        input  out_col,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/matrix_result_streamer.sv
// Snapshots the multiplier's flat M*P result on its done pulse and streams the
// elements row-major over a valid/ready interface, one element per beat.
module matrix_result_streamer #(
    parameter int DATA_WIDTH = 8,
    parameter int M          = 8,
    parameter int P          = 8,
    parameter int ROW_W      = 3,
    parameter int COL_W      = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_done,
    input  logic [M*P*DATA_WIDTH-1:0]   in_result,
    matrix_result_streamer_if.master    stream,
    output logic                        busy,
    output logic                        overrun,
    input  logic                        clr_overrun,
    output logic [7:0]                  frame_cnt
);

    localparam int N     = M * P;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(M - 1);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(P - 1);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] snap [N];
    logic [ROW_W-1:0]      row;
    logic [COL_W-1:0]      col;
    logic [IDX_W-1:0]      idx;
    logic                  valid_q;
    logic                  last_q;

    logic fire;
    logic capture;

    assign fire    = valid_q & stream.out_ready;
    // Capture is legal when idle or exactly as the final beat leaves, giving
    // back-to-back frames with no idle bubble.
    assign capture = in_done & ((state == IDLE) | (fire & last_q));

    // NOTE: sequential state uses non-blocking assignments only; later assignments
    // in the same block deliberately override earlier ones (capture beats advance).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            busy      <= 1'b0;
            row       <= '0;
            col       <= '0;
            idx       <= '0;
            overrun   <= 1'b0;
            frame_cnt <= '0;
            // NOTE: the snapshot is a flop array, not a RAM, so it is cleared on reset
            // like any other state; a true memory macro would not get this loop.
            for (int e = 0; e < N; e++) begin
                snap[e] <= '0;
            end
        end else begin
            if (in_done && !capture) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end

            if (fire) begin
                if (last_q) begin
                    frame_cnt <= frame_cnt + 8'd1;
                    state     <= IDLE;
                    valid_q   <= 1'b0;
                    busy      <= 1'b0;
                    last_q    <= 1'b0;
                    row       <= '0;
                    col       <= '0;
                    idx       <= '0;
                end else begin
                    idx    <= idx + IDX_W'(1);
                    // The element after index N-2 is the final one of the frame.
                    last_q <= (idx == IDX_W'(N - 2));
                    if (col == COL_MAX) begin
                        col <= '0;
                        row <= (row == ROW_MAX) ? '0 : row + ROW_W'(1);
                    end else begin
                        col <= col + COL_W'(1);
                    end
                end
            end

            if (capture) begin
                state   <= STREAM;
                valid_q <= 1'b1;
                busy    <= 1'b1;
                row     <= '0;
                col     <= '0;
                idx     <= '0;
                last_q  <= (N == 1);
                for (int e = 0; e < N; e++) begin
                    snap[e] <= in_result[e*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    assign stream.out_valid = valid_q;
    assign stream.out_data  = snap[idx];
    assign stream.out_row   = row;
    assign stream.out_col   = col;
    assign stream.out_last  = last_q;

endmodule
